pe_column_ctrl: RTL

//  Sequencer for one column of N_PE processing elements (8b filter/ifmap, 10b psum, 3-tap scratchpads).

---
 rtl/pe_column_ctrl.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pe_column_ctrl.sv
// pe_column_ctrl
//   Sequencer for one column of N_PE processing elements. Routes a single
//   valid/ready byte stream into the PE filter/ifmap scratchpads with one-hot
//   load strobes, issues staggered start_conv pulses (one PE per cycle, top PE
//   first), captures the bottom PE psum into an output valid/ready register,
//   and repeats for cfg_num_out_i sliding ifmap windows.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   cfg_go_i             job start, sampled only while idle
//   cfg_num_out_i        windows per job (0 is treated as 1)
//   in_data_i/valid/rdy  filter/ifmap byte stream
//   pe_data_o            byte broadcast to all PEs (in_data_i on accepted bytes)
//   filt_load_o          one-hot filter scratchpad load strobes
//   ifmap_load_o         one-hot ifmap scratchpad load strobes
//   start_conv_o         one-hot start_conv strobes
//   psum_i/psum_valid_i  result of the bottom PE
//   out_data_o/valid/rdy column result register
//   busy_o               high whenever a job is in progress
//   done_o               pulses in the cycle the last result is accepted
//
// Optional build macro PE_CTRL_PERF_EN adds stall_cnt_o (cycles in OUT with
// out_ready_i low) and job_cyc_o (busy cycles of the current/last job). Both
// saturate at 16'hFFFF and clear when a job is accepted.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for cfg_go_i
// LOAD_F | streaming 3 filter taps into each PE, PE0 first
// LOAD_I | streaming ifmap: 3 taps per PE (first window) or 1 per PE (slide)
// RUN    | one start_conv pulse per cycle, PE0 .. PE(N_PE-1)
// WAIT   | waiting for the bottom PE psum
// OUT    | holding the result until the consumer accepts it

module pe_column_ctrl #(
    parameter int N_PE   = 3,
    parameter int NOUT_W = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cfg_go_i,
    input  logic [NOUT_W-1:0] cfg_num_out_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [7:0]        pe_data_o,
    output logic [N_PE-1:0]   filt_load_o,
    output logic [N_PE-1:0]   ifmap_load_o,
    output logic [N_PE-1:0]   start_conv_o,
    input  logic [9:0]        psum_i,
    input  logic              psum_valid_i,
    output logic [9:0]        out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
`ifdef PE_CTRL_PERF_EN
    ,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       job_cyc_o
`endif
);

    localparam int PE_W = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam logic [PE_W-1:0] PE_LAST = PE_W'(N_PE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_F,
        S_LOAD_I,
        S_RUN,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [PE_W-1:0]   pe_q, pe_d;          // PE currently being loaded
    logic [1:0]        tap_q, tap_d;        // tap within that PE
    logic              slide_q, slide_d;    // 1: ifmap load is a 1-byte-per-PE slide
    logic [PE_W-1:0]   run_q, run_d;        // PE receiving start_conv this cycle
    logic [NOUT_W-1:0] out_rem_q, out_rem_d; // results still owed, counts down to 1
    logic [9:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic              go_acc;
    logic              xfer;
    logic [N_PE-1:0]   pe_sel;
    logic [N_PE-1:0]   run_sel;

    assign in_ready_o = (state_q == S_LOAD_F) || (state_q == S_LOAD_I);
    assign accept     = in_ready_o && in_valid_i;
    assign go_acc     = (state_q == S_IDLE) && cfg_go_i;
    assign xfer       = (state_q == S_OUT) && out_valid_q && out_ready_i;

    always_comb begin
        pe_sel  = '0;
        run_sel = '0;
        for (int i = 0; i < N_PE; i++) begin
            pe_sel[i]  = (pe_q == PE_W'(i));
            run_sel[i] = (run_q == PE_W'(i));
        end
    end

    assign pe_data_o    = accept ? in_data_i : 8'd0;
    assign filt_load_o  = (accept && state_q == S_LOAD_F) ? pe_sel : '0;
    assign ifmap_load_o = (accept && state_q == S_LOAD_I) ? pe_sel : '0;
    assign start_conv_o = (state_q == S_RUN) ? run_sel : '0;
    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = xfer && (out_rem_q == NOUT_W'(1));

    always_comb begin
        state_d     = state_q;
        pe_d        = pe_q;
        tap_d       = tap_q;
        slide_d     = slide_q;
        run_d       = run_q;
        out_rem_d   = out_rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_go_i) begin
                    out_rem_d = (cfg_num_out_i == '0) ? NOUT_W'(1) : cfg_num_out_i;
                    pe_d      = '0;
                    tap_d     = 2'd0;
                    slide_d   = 1'b0;
                    state_d   = S_LOAD_F;
                end
            end
            S_LOAD_F: begin
                if (accept) begin
                    if (tap_q == 2'd2) begin
                        tap_d = 2'd0;
                        if (pe_q == PE_LAST) begin
                            pe_d    = '0;
                            state_d = S_LOAD_I;
                        end else begin
                            pe_d = pe_q + PE_W'(1);
                        end
                    end else begin
                        tap_d = tap_q + 2'd1;
                    end
                end
            end
            S_LOAD_I: begin
                if (accept) begin
                    // A slide pushes a single new tap per PE; the first window fills all three.
                    if (slide_q || tap_q == 2'd2) begin
                        tap_d = 2'd0;
                        if (pe_q == PE_LAST) begin
                            pe_d    = '0;
                            run_d   = '0;
                            state_d = S_RUN;
                        end else begin
                            pe_d = pe_q + PE_W'(1);
                        end
                    end else begin
                        tap_d = tap_q + 2'd1;
                    end
                end
            end
            S_RUN: begin
                if (run_q == PE_LAST) begin
                    run_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    run_d = run_q + PE_W'(1);
                end
            end
            S_WAIT: begin
                if (psum_valid_i) begin
                    out_data_d  = psum_i;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
                    if (out_rem_q == NOUT_W'(1)) begin
                        out_rem_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        out_rem_d = out_rem_q - NOUT_W'(1);
                        slide_d   = 1'b1;
                        pe_d      = '0;
                        tap_d     = 2'd0;
                        state_d   = S_LOAD_I;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            pe_q        <= '0;
            tap_q       <= 2'd0;
            slide_q     <= 1'b0;
            run_q       <= '0;
            out_rem_q   <= '0;
            out_data_q  <= 10'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pe_q        <= pe_d;
            tap_q       <= tap_d;
            slide_q     <= slide_d;
            run_q       <= run_d;
            out_rem_q   <= out_rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef PE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] job_cyc_q, job_cyc_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        job_cyc_d   = job_cyc_q;
        if (go_acc) begin
            stall_cnt_d = 16'd0;
            job_cyc_d   = 16'd0;
        end else begin
            if (state_q == S_OUT && !out_ready_i && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (busy_o && job_cyc_q != 16'hFFFF) begin
                job_cyc_d = job_cyc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= 16'd0;
            job_cyc_q   <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            job_cyc_q   <= job_cyc_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign job_cyc_o   = job_cyc_q;
`endif

endmodule
